// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, FSM states,
// the latched-instruction payload and opcode classification helpers.
package alu_seq_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  // Opcodes shared with the ALU encoding
  localparam logic [OP_W-1:0] OP_ADD        = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD_CARRY  = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB        = 5'd2;
  localparam logic [OP_W-1:0] OP_SUB_BORROW = 5'd3;
  localparam logic [OP_W-1:0] OP_MUL        = 5'd4;
  localparam logic [OP_W-1:0] OP_LOAD       = 5'b10000;
  localparam logic [OP_W-1:0] OP_STORE      = 5'b10001;

  localparam logic [OP_W-1:0] MUL_OP      = OP_MUL;
  localparam logic [OP_W-1:0] ILLEGAL_MIN = 5'd18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB_LO,
    S_WB_HI
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Ops whose result bit 32 is a carry/borrow out
  function automatic logic is_carry_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ADD_CARRY) ||
           (op == OP_SUB) || (op == OP_SUB_BORROW);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 32x32 register file: async clear, one synchronous write port,
// combinational read ports for rs, rt and debug.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_rs_addr,
  input  logic [REG_W-1:0]  i_rt_addr,
  input  logic [REG_W-1:0]  i_dbg_addr,
  output logic [DATA_W-1:0] o_rs_data_c,
  output logic [DATA_W-1:0] o_rt_data_c,
  output logic [DATA_W-1:0] o_dbg_data_c
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rs_data_c  = r_mem[i_rs_addr];
  assign o_rt_data_c  = r_mem[i_rt_addr];
  assign o_dbg_data_c = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the shared combinational ALU: accepts one
// instruction, reads operands, drives the ALU, captures the 64-bit result
// and writes it back (MUL high word to rd+1).
// Optional feature macro: ALU_SEQ_CARRY_EN (carry_flag register).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [REG_W-1:0]    instr_rd,
  input  logic [REG_W-1:0]    instr_rs,
  input  logic [REG_W-1:0]    instr_rt,
  input  logic [DATA_W-1:0]   instr_imm,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [2*DATA_W-1:0] alu_out,
  output logic                done,
  output logic [REG_W-1:0]    done_rd,
  output logic [DATA_W-1:0]   done_data,
  output logic                store_valid,
  output logic [DATA_W-1:0]   store_data,
  output logic                err,
  output logic                carry_flag,
  input  logic [REG_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

  state_t              r_state, w_state_nxt;
  instr_t              r_instr;
  logic [2*DATA_W-1:0] r_result;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic                r_instr_ready;
  logic                r_done, w_done_nxt;
  logic [REG_W-1:0]    r_done_rd, w_done_rd_nxt;
  logic [DATA_W-1:0]   r_done_data, w_done_data_nxt;
  logic                r_store_valid, w_store_valid_nxt;
  logic [DATA_W-1:0]   r_store_data, w_store_data_nxt;
  logic                r_err, w_err_nxt;

  logic                w_accept;
  logic                w_we;
  logic [REG_W-1:0]    w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rs_data, w_rt_data;

  assign w_accept = (r_state == S_IDLE) && instr_valid;

  alu_seq_regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .i_we         (w_we),
    .i_waddr      (w_waddr),
    .i_wdata      (w_wdata),
    .i_rs_addr    (r_instr.rs),
    .i_rt_addr    (r_instr.rt),
    .i_dbg_addr   (dbg_addr),
    .o_rs_data_c  (w_rs_data),
    .o_rt_data_c  (w_rt_data),
    .o_dbg_data_c (dbg_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, writeback port and next values of the pulse outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_we              = 1'b0;
    w_waddr           = r_instr.rd;
    w_wdata           = r_result[DATA_W-1:0];
    w_done_nxt        = 1'b0;
    w_done_rd_nxt     = r_done_rd;
    w_done_data_nxt   = r_done_data;
    w_store_valid_nxt = 1'b0;
    w_store_data_nxt  = r_store_data;
    w_err_nxt         = 1'b0;
    unique case (r_state)
      S_IDLE:  if (instr_valid) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB_LO;
      S_WB_LO: begin
        w_done_rd_nxt = r_instr.rd;
        if (r_instr.op >= ILLEGAL_MIN) begin
          w_err_nxt       = 1'b1;
          w_done_data_nxt = '0;
        end else if (r_instr.op == OP_LOAD) begin
          w_we            = 1'b1;
          w_wdata         = r_instr.imm;
          w_done_data_nxt = r_instr.imm;
        end else if (r_instr.op == OP_STORE) begin
          w_store_valid_nxt = 1'b1;
          w_store_data_nxt  = w_rs_data;
          w_done_data_nxt   = w_rs_data;
        end else begin
          w_we            = 1'b1;
          w_done_data_nxt = r_result[DATA_W-1:0];
        end
        // MUL into R31 drops the high word rather than wrapping to R0
        if ((r_instr.op == MUL_OP) && (r_instr.rd != LAST_REG)) begin
          w_state_nxt = S_WB_HI;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_WB_HI: begin
        w_we            = 1'b1;
        w_waddr         = r_instr.rd + REG_W'(1);
        w_wdata         = r_result[2*DATA_W-1:DATA_W];
        w_done_rd_nxt   = r_instr.rd + REG_W'(1);
        w_done_data_nxt = r_result[2*DATA_W-1:DATA_W];
        w_done_nxt      = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction latch, ALU operand/result staging and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr       <= '0;
      r_result      <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_instr_ready <= 1'b1;
      r_done        <= 1'b0;
      r_done_rd     <= '0;
      r_done_data   <= '0;
      r_store_valid <= 1'b0;
      r_store_data  <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr <= '{op: instr_op, rd: instr_rd, rs: instr_rs,
                     rt: instr_rt, imm: instr_imm};
      end
      if (r_state == S_READ) begin
        r_alu_a  <= w_rs_data;
        r_alu_b  <= w_rt_data;
        r_alu_op <= r_instr.op;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_out;
      end
      r_instr_ready <= (w_state_nxt == S_IDLE);
      r_done        <= w_done_nxt;
      r_done_rd     <= w_done_rd_nxt;
      r_done_data   <= w_done_data_nxt;
      r_store_valid <= w_store_valid_nxt;
      r_store_data  <= w_store_data_nxt;
      r_err         <= w_err_nxt;
    end
  end

`ifdef ALU_SEQ_CARRY_EN
  logic r_carry;

  // Carry/borrow out of add/sub ops, held across all other ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry <= 1'b0;
    end else if ((r_state == S_WB_LO) && is_carry_op(r_instr.op)) begin
      r_carry <= r_result[DATA_W];
    end
  end

  assign carry_flag = r_carry;
`else
  assign carry_flag = 1'b0;
`endif

  assign instr_ready = r_instr_ready;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign done        = r_done;
  assign done_rd     = r_done_rd;
  assign done_data   = r_done_data;
  assign store_valid = r_store_valid;
  assign store_data  = r_store_data;
  assign err         = r_err;

endmodule
